// File: rtl/ksa_share_ctrl.sv
// +----------------------------------------------------------------------------+
// | ksa_share_ctrl: round-robin time-sharing controller for one external       |
// | Kogge-Stone adder. Optional macro KSA_MC2_EN: 2-cycle adder evaluation.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module ksa_share_ctrl #(
  parameter int NREQ = 4,
  parameter int W    = 12,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0]   req_cin,
  output logic [W-1:0]      add_x,
  output logic [W-1:0]      add_y,
  output logic              add_cin,
  input  logic [W:0]        add_s,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W:0]        rsp_sum,
  output logic              busy
);

  if ((2 ** IDW) < NREQ) begin : g_cfg_err
    $error("ksa_share_ctrl: IDW=%0d cannot index NREQ=%0d requesters", IDW, NREQ);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [IDW-1:0] C_PTR_RST = IDW'(NREQ - 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0]   add_x_q, add_x_d;
  logic [W-1:0]   add_y_q, add_y_d;
  logic           add_cin_q, add_cin_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W:0]     rsp_sum_q, rsp_sum_d;
`ifdef KSA_MC2_EN
  logic           mc_cnt_q, mc_cnt_d;
`endif

  logic           any_valid;
  logic           hi_hit;
  logic [IDW-1:0] hi_idx, lo_idx, gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [W-1:0]   gnt_x, gnt_y;
  logic           gnt_cin;

  // Round-robin: the lowest valid index above rr_ptr wins; otherwise wrap to the lowest valid.
  always_comb begin
    any_valid = |req_valid;
    hi_hit    = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = i[IDW-1:0];
        if (i[IDW-1:0] > rr_ptr_q) begin
          hi_idx = i[IDW-1:0];
          hi_hit = 1'b1;
        end
      end
    end
    gnt_idx = hi_hit ? hi_idx : lo_idx;
    gnt_oh  = '0;
    gnt_x   = '0;
    gnt_y   = '0;
    gnt_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (any_valid && (gnt_idx == i[IDW-1:0])) begin
        gnt_oh[i] = 1'b1;
        gnt_x     = req_x[i*W +: W];
        gnt_y     = req_y[i*W +: W];
        gnt_cin   = req_cin[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    add_x_d     = add_x_q;
    add_y_d     = add_y_q;
    add_cin_d   = add_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
`ifdef KSA_MC2_EN
    mc_cnt_d    = mc_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          add_x_d   = gnt_x;
          add_y_d   = gnt_y;
          add_cin_d = gnt_cin;
          rsp_id_d  = gnt_idx;
          rr_ptr_d  = gnt_idx;
          state_d   = S_EVAL;
`ifdef KSA_MC2_EN
          mc_cnt_d  = 1'b0;
`endif
        end
      end
      S_EVAL: begin
`ifdef KSA_MC2_EN
        if (!mc_cnt_q) begin
          mc_cnt_d = 1'b1;
        end else begin
          rsp_sum_d   = add_s;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
`else
        rsp_sum_d   = add_s;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= C_PTR_RST;
      add_x_q     <= '0;
      add_y_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
`ifdef KSA_MC2_EN
      mc_cnt_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      add_x_q     <= add_x_d;
      add_y_q     <= add_y_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
`ifdef KSA_MC2_EN
      mc_cnt_q    <= mc_cnt_d;
`endif
    end
  end

  // Ready is a combinational grant, gated off while reset is asserted.
  assign req_ready = (rst_n && (state_q == S_IDLE)) ? gnt_oh : '0;
  assign add_x     = add_x_q;
  assign add_y     = add_y_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ksa_share_ctrl.sv
// Self-checking bench for ksa_share_ctrl: directed vectors, corner sequences and a
// randomized run against a transaction-level reference model.
`default_nettype none

module tb_ksa_share_ctrl;
  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int IDW  = 2;
  localparam int NCYC = 600;
`ifdef KSA_MC2_EN
  localparam int EVAL_CYC = 2;
`else
  localparam int EVAL_CYC = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x = '0;
  logic [NREQ*W-1:0] req_y = '0;
  logic [NREQ-1:0]   req_cin = '0;
  logic [W-1:0]      add_x, add_y;
  logic              add_cin;
  logic [W:0]        add_s;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [W:0]        rsp_sum;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The external combinational adder.
  assign add_s = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

  ksa_share_ctrl #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_s(add_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );

  typedef struct {
    int         id;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic       cin;
    logic [W:0] sum;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
    req_cin[i]      = c;
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Spec-level arbiter: first valid index after the last grant, with wrap.
  function automatic int model_arb(input logic [NREQ-1:0] v, input int ptr);
    int r = -1;
    for (int k = NREQ; k >= 1; k--) if (v[(ptr + k) % NREQ]) r = (ptr + k) % NREQ;
    return r;
  endfunction

  task automatic wait_rsp(input string name, output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) chk({name, "_timeout"}, 32'(rsp_valid), 32'd1);
  endtask

  // One isolated transaction; entered and left at 1 time unit after a rising edge, idle DUT.
  task automatic single_txn(input int id, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic [W:0] exp_sum);
    int n;
    rsp_ready = 1'b0;
    set_req(id, x, y, c);
    req_valid = NREQ'(1) << id;
    #1;
    chk("txn_grant", 32'(req_ready), 32'(NREQ'(1) << id));
    @(posedge clk); #1;
    req_valid = '0;
    chk("txn_eval_ready", 32'(req_ready), 32'd0);
    chk("txn_busy", 32'(busy), 32'd1);
    wait_rsp("txn", n);
    chk("txn_latency", 32'(n), 32'(EVAL_CYC));
    chk("txn_sum", 32'(rsp_sum), 32'(exp_sum));
    chk("txn_id", 32'(rsp_id), 32'(id));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("txn_done_valid", 32'(rsp_valid), 32'd0);
    chk("txn_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   exp_order[5];
    int   order[$];
    int   grants, resps, cyc, n, g, age, mptr, m_id;
    logic busy_m, exp_rv;
    logic [W:0] m_sum;
    logic [NREQ-1:0] pend;
    logic [W-1:0] px[NREQ];
    logic [W-1:0] py[NREQ];
    logic pc[NREQ];
    int   wait_cnt[NREQ];

    tbl[0] = '{0, 12'hFFF, 12'h001, 1'b0, 13'h1000};
    tbl[1] = '{1, 12'h000, 12'h000, 1'b0, 13'h0000};
    tbl[2] = '{2, 12'hFFF, 12'hFFF, 1'b1, 13'h1FFF};
    tbl[3] = '{3, 12'h800, 12'h800, 1'b0, 13'h1000};
    tbl[4] = '{1, 12'h123, 12'h456, 1'b1, 13'h057A};
    tbl[5] = '{0, 12'h7FF, 12'h7FF, 1'b1, 13'h0FFF};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset with every requester asserting valid.
    rst_n = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, W'(i), 12'h100, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_add_x", 32'(add_x), 32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("first_grant", 32'(req_ready), 32'b0001);

    // All requesters valid: round-robin order and per-requester sums.
    grants = 0; resps = 0; cyc = 0;
    while ((grants < 5 || resps < 5) && cyc < 80) begin
      if (req_ready != '0 && grants < 5) begin
        order.push_back(oh2idx(req_ready));
        grants++;
      end
      if (rsp_valid && rsp_ready && resps < 5) begin
        chk("rr_sum", 32'(rsp_sum), 32'(13'h101 + 13'(exp_order[resps])));
        chk("rr_id", 32'(rsp_id), 32'(exp_order[resps]));
        resps++;
      end
      @(posedge clk); #1;
      if (grants == 5) req_valid = '0;
      #1;
      cyc++;
    end
    chk("rr_complete", 32'(grants == 5 && resps == 5), 32'd1);
    for (int k = 0; k < order.size(); k++) chk("rr_order", 32'(order[k]), 32'(exp_order[k]));
    rsp_ready = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    for (int k = 0; k < 6; k++) single_txn(tbl[k].id, tbl[k].x, tbl[k].y, tbl[k].cin, tbl[k].sum);

    // Backpressure: response held for 10 cycles, next grant one cycle after handshake.
    set_req(1, 12'h001, 12'h100, 1'b1);
    set_req(2, 12'h002, 12'h100, 1'b1);
    req_valid = 4'b0110;
    #1;
    chk("bp_grant1", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_rsp("bp", n);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_sum", 32'(rsp_sum), 32'h102);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp("bp2", n);
    chk("bp2_sum", 32'(rsp_sum), 32'h103);
    chk("bp2_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset while the adder is being evaluated.
    set_req(3, 12'h005, 12'h006, 1'b0);
    req_valid = 4'b1000;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_busy_rst", 32'(busy), 32'd0);
    chk("mid_ready_rst", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rsp_valid_hold", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    repeat (EVAL_CYC + 2) @(posedge clk);
    #1;
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    single_txn(0, 12'h7FF, 12'h7FF, 1'b1, 13'h0FFF);

    // Randomized run against the transaction-level model.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pend = '0; busy_m = 1'b0; age = 0; mptr = NREQ - 1; m_id = 0; m_sum = '0;
    for (int i = 0; i < NREQ; i++) begin
      px[i] = '0; py[i] = '0; pc[i] = 1'b0; wait_cnt[i] = 0;
    end
    for (int c = 0; c < NCYC + 300; c++) begin
      if (c < NCYC) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i] && $urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            px[i] = W'($urandom);
            py[i] = W'($urandom);
            pc[i] = 1'($urandom);
            wait_cnt[i] = 0;
          end
        end
      end else if (pend == '0 && !busy_m) begin
        break;
      end
      for (int i = 0; i < NREQ; i++) set_req(i, px[i], py[i], pc[i]);
      req_valid = pend;
      rsp_ready = (c >= NCYC) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      exp_rv = busy_m && (age >= EVAL_CYC);
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (busy_m) begin
        chk("rnd_ready_busy", 32'(req_ready), 32'd0);
        if (exp_rv && rsp_ready) begin
          chk("rnd_id", 32'(rsp_id), 32'(m_id));
          chk("rnd_sum", 32'(rsp_sum), 32'(m_sum));
          busy_m = 1'b0;
        end else begin
          age++;
        end
      end else if (pend != '0) begin
        g = model_arb(pend, mptr);
        chk("rnd_grant", 32'(req_ready), 32'(NREQ'(1) << g));
        chk("rnd_fairness", 32'(wait_cnt[g] <= NREQ - 1), 32'd1);
        for (int i = 0; i < NREQ; i++) if (i != g && pend[i]) wait_cnt[i]++;
        m_id = g;
        m_sum = {1'b0, px[g]} + {1'b0, py[g]} + {{W{1'b0}}, pc[g]};
        busy_m = 1'b1;
        age = 0;
        mptr = g;
        pend[g] = 1'b0;
      end else begin
        chk("rnd_idle_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
    end
    chk("rnd_drained", 32'(pend == '0 && !busy_m), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
